// File: rtl/enc_event_2x4_pkg.sv
// rtl/enc_event_2x4_pkg.sv - shared width default, FSM state type and highest-set-bit helper
package enc_event_2x4_pkg;

  localparam int W_DEF = 2;

  typedef enum logic {IDLE, PRESENT} state_t;

  // Returns the index of the highest set bit (0 for an empty mask); masks up to 32 lines
  function automatic int unsigned hi_index(input logic [31:0] mask);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/enc_event_2x4_if.sv
// rtl/enc_event_2x4_if.sv - code/valid/ready handshake between encoder and consumer
interface enc_event_2x4_if
  import enc_event_2x4_pkg::*;
#(
  parameter int W = W_DEF
);
  logic [W-1:0] A;
  logic         V;
  logic         R;

  modport master (output A, output V, input R);
  modport slave  (input A, input V, output R);
endinterface

// File: rtl/enc_event_2x4_prio_enc.sv
// rtl/enc_event_2x4_prio_enc.sv - combinational N->W highest-set-bit finder with any flag
module prio_enc
  import enc_event_2x4_pkg::*;
#(
  parameter  int W = W_DEF,
  localparam int N = 1 << W
) (
  input  logic [N-1:0] i_mask,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  assign o_idx = W'(hi_index(32'(i_mask)));
  assign o_any = |i_mask;
endmodule

// File: rtl/enc_event_2x4.sv
// rtl/enc_event_2x4.sv - rising-edge event encoder, highest index first; ENC_OVERRUN_EN enables sticky ovr
module enc_event_2x4
  import enc_event_2x4_pkg::*;
#(
  parameter  int W = W_DEF,
  localparam int N = 1 << W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   E,
  input  logic [N-1:0]           D,
  enc_event_2x4_if.master        bus,
  output logic [N-1:0]           pend,
  output logic                   ovr
);
  logic [N-1:0] r_d_q;
  logic [N-1:0] r_pend;
  state_t       r_state;
  logic [W-1:0] r_a;
  logic         r_v;

  logic [N-1:0] w_rise;
  logic [N-1:0] w_clr;
  logic [W-1:0] w_idx;
  logic         w_any;
  logic         w_load;

  prio_enc #(.W(W)) u_prio (
    .i_mask (r_pend),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_rise = D & ~r_d_q & {N{E}};
  // A new code is taken whenever the output slot is free or being handed off this edge
  assign w_load = w_any && ((r_state == IDLE) || bus.R);
  assign w_clr  = w_load ? (N'(1) << w_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_q   <= D;
      r_pend  <= '0;
      r_state <= IDLE;
      r_a     <= '0;
      r_v     <= 1'b0;
    end else begin
      r_d_q  <= D;
      r_pend <= (r_pend & ~w_clr) | w_rise;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= w_idx;
            r_v     <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.R) begin
            if (w_any) begin
              r_a <= w_idx;
            end else begin
              r_v     <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ENC_OVERRUN_EN
  logic r_ovr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (|(w_rise & r_pend & ~w_clr)) begin
      r_ovr <= 1'b1;
    end
  end
  assign ovr = r_ovr;
`else
  assign ovr = 1'b0;
`endif

  assign bus.A = r_a;
  assign bus.V = r_v;
  assign pend  = r_pend;
endmodule

// File: tb/tb_enc_event_2x4.sv
// tb/tb_enc_event_2x4.sv - directed and random checks of enc_event_2x4 against a queue-level model
module tb_enc_event_2x4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       E;
  logic [3:0] D;
  logic [3:0] pend;
  logic       ovr;
  int         n_pass = 0;
  int         n_total = 0;
  int         dut_a1 = 0;

  // model state: last seen lines, pending set, presented slot, sticky flag
  logic [3:0] m_dq = '0;
  logic [3:0] m_pend = '0;
  logic       m_v = 1'b0;
  logic [1:0] m_a = '0;
  logic       m_ovr = 1'b0;

`ifdef ENC_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  enc_event_2x4_if bus ();

  enc_event_2x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .E     (E),
    .D     (D),
    .bus   (bus),
    .pend  (pend),
    .ovr   (ovr)
  );

  function automatic int top_bit(input logic [3:0] m);
    int h;
    h = -1;
    for (int i = 0; i < 4; i++) if (m[i]) h = i;
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_step();
    logic [3:0] rise;
    logic [3:0] clr;
    int h;
    if (!rst_n) begin
      m_dq = D; m_pend = '0; m_v = 1'b0; m_a = '0; m_ovr = 1'b0;
    end else begin
      rise = D & ~m_dq & {4{E}};
      clr = '0;
      h = top_bit(m_pend);
      if (!m_v || bus.R) begin
        if (h >= 0) begin
          m_a = h[1:0]; m_v = 1'b1; clr[h] = 1'b1;
        end else begin
          m_v = 1'b0;
        end
      end
`ifdef ENC_OVERRUN_EN
      if ((rise & m_pend & ~clr) != 4'b0) m_ovr = 1'b1;
`endif
      m_pend = (m_pend & ~clr) | rise;
      m_dq = D;
    end
  endtask

  task automatic compare_all();
    check("V", 32'(bus.V), 32'(m_v));
    check("pend", 32'(pend), 32'(m_pend));
    check("ovr", 32'(ovr), 32'(m_ovr));
    if (m_v) check("A", 32'(bus.A), 32'(m_a));
  endtask

  task automatic cycle();
    if (bus.V && bus.R && bus.A == 2'd1) dut_a1++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; E = 1'b1; D = 4'b0100; bus.R = 1'b1;
    repeat (3) cycle();
    check("rst_V", 32'(bus.V), 32'd0);
    rst_n = 1'b1;
    repeat (5) begin
      cycle();
      check("hold_noV", 32'(bus.V), 32'd0);
      check("hold_pend", 32'(pend), 32'd0);
    end

    D = 4'b0000; cycle();
    D = 4'b0010; cycle(); cycle();
    check("single_V", 32'(bus.V), 32'd1);
    check("single_A", 32'(bus.A), 32'd1);
    cycle();
    check("single_drain", 32'(bus.V), 32'd0);

    D = 4'b0000; cycle();
    D = 4'b1011; cycle(); cycle();
    check("multi_A3", 32'(bus.A), 32'd3);
    cycle(); check("multi_A1", 32'(bus.A), 32'd1);
    cycle(); check("multi_A0", 32'(bus.A), 32'd0);
    cycle(); check("multi_end", 32'(bus.V), 32'd0);

    D = 4'b0000; cycle();
    bus.R = 1'b0; D = 4'b1000; cycle(); cycle();
    check("stall_A3", 32'(bus.A), 32'd3);
    D = 4'b1100; cycle(); cycle();
    check("stall_hold", 32'(bus.A), 32'd3);
    check("stall_pend", 32'(pend), 32'd4);
    bus.R = 1'b1; cycle();
    check("stall_A2", 32'(bus.A), 32'd2);
    D = 4'b0000; cycle();
    check("stall_end", 32'(bus.V), 32'd0);

    E = 1'b0;
    repeat (6) begin
      D = 4'($urandom); cycle();
      check("gate_pend", 32'(pend), 32'd0);
      check("gate_V", 32'(bus.V), 32'd0);
    end
    D = 4'b0000; cycle();
    E = 1'b1; cycle();
    D = 4'b0001; cycle(); cycle();
    check("gate_A0", 32'(bus.A), 32'd0);
    check("gate_V1", 32'(bus.V), 32'd1);
    cycle();

    D = 4'b0000; bus.R = 1'b0; cycle();
    dut_a1 = 0;
    D = 4'b1000; cycle(); cycle();
    D = 4'b1010; cycle();
    D = 4'b1000; cycle();
    D = 4'b1010; cycle(); cycle();
    check("ovr_flag", 32'(ovr), 32'(OVR_EXP));
    bus.R = 1'b1;
    repeat (4) cycle();
    check("ovr_one_xfer", 32'(dut_a1), 32'd1);

    repeat (600) begin
      E = ($urandom_range(0, 3) != 0);
      D = 4'($urandom);
      bus.R = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 60) != 0);
      cycle();
      rst_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
